dff_delay_line: RTL and testbench
=================================

DFF_DELAY_LINE -- requirements
Module: dff_delay_line

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage, legal range 1..64.
REQ-002 Parameter DEPTH, default 4: number of register stages, legal range 1..32.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  advance enable; when 0 all stages hold.
REQ-006 flush  input  1  synchronous clear of all valid bits.
REQ-007 d  input  WIDTH  data into stage 0.
REQ-008 d_valid  input  1  qualifies d.
REQ-009 q  output  WIDTH  data of stage DEPTH-1.
REQ-010 q_valid  output  1  valid bit of stage DEPTH-1.
REQ-011 fill_count  output  $clog2(DEPTH+1)  number of stages whose valid bit is set.

Function
REQ-012 On a rising clk edge with en=1 and flush=0, stage 0 SHALL load {d_valid, d} and stage k SHALL load stage k-1 for k=1..DEPTH-1.
REQ-013 With en=0 and flush=0, every stage and its valid bit SHALL hold.
REQ-014 A word with d_valid=1 SHALL appear on q with q_valid=1 after exactly DEPTH enabled edges; disabled edges SHALL NOT count toward latency.
REQ-015 q and q_valid SHALL be driven directly from stage DEPTH-1 flops, with no combinational path from d, en or flush.
REQ-016 flush=1 SHALL clear all valid bits on the next edge regardless of en; data bits SHALL hold; flush SHALL take priority over en.
REQ-017 fill_count SHALL equal the population count of the valid bits, registered consistently with them, and SHALL be in the range 0..DEPTH.
REQ-018 Stage data SHALL load even when d_valid=0; only the valid bit marks it meaningful.
REQ-019 DEPTH=1 SHALL give a single enabled D flip-flop with valid, with a latency of 1.

Reset
REQ-020 rst=1 SHALL immediately, without a clock, force all stage data to 0, all valid bits to 0, q=0, q_valid=0 and fill_count=0.
REQ-021 Assertion of rst mid-stream SHALL discard all in-flight words.
REQ-022 The first enabled edge after rst deasserts SHALL capture d normally.

Configuration
REQ-023 Macro DFF_DELAY_LINE_PARITY_EN SHALL control a parity feature, as follows.
REQ-024 When DFF_DELAY_LINE_PARITY_EN is defined:
- each stage SHALL carry an extra even-parity bit computed from d at stage 0;
- input perr_inject (1 bit) SHALL invert the stored parity bit at stage 0;
- output q_perr (1 bit) SHALL equal q_valid & (^q ^ stored parity of stage DEPTH-1);
- rst SHALL clear the parity bits.
REQ-025 When DFF_DELAY_LINE_PARITY_EN is undefined:
- no parity flops SHALL exist;
- perr_inject and q_perr SHALL be absent from the port list;
- the remaining ports and their behaviour SHALL be unchanged.

Structure
REQ-026 Shared package dff_pkg SHALL hold:
- WIDTH_MAX=64 and DEPTH_MAX=32;
- a function that returns the fill_count width for a given DEPTH.
REQ-027 One sub-module, dff_stage, SHALL be used: a WIDTH-bit plus valid register with async active-high rst, en and synchronous valid clear, instantiated DEPTH times in a generate loop.
REQ-028 Parameter legality (REQ-001, REQ-002) SHALL be checked at elaboration, and an illegal value SHALL be a fatal error.

Verification
REQ-029 Latency: WIDTH=8, DEPTH=4, en=1, d=8'hA5 with d_valid=1 for one cycle -> q=8'hA5 and q_valid=1 exactly 4 edges later, for one cycle.
REQ-030 Stall: the same word with en=0 on edges 2 and 3 -> q=8'hA5 appears on edge 6; fill_count stays 1 throughout the stall.
REQ-031 Fill and flush: d_valid=1 for 4 cycles with d=1,2,3,4 -> fill_count reaches 4; then flush=1 with en=1 -> fill_count=0, q_valid=0 next edge, and q holds 8'h01.
REQ-032 Async reset: rst pulsed between edges while fill_count=3 -> q=0, q_valid=0 and fill_count=0 before the next edge.
REQ-033 Boundary: DEPTH=1, d=8'h3C with d_valid=1 -> q=8'h3C after 1 edge; d_valid=0 on the next cycle -> q_valid=0.
REQ-034 Parity (macro defined): perr_inject=1 with d=8'h01 and d_valid=1 -> q_perr=1 after 4 edges; perr_inject=0 -> q_perr stays 0.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared limits and sizing helpers for the dff_delay_line pipeline.
package dff_pkg;

   localparam int unsigned WIDTH_MAX = 64;
   localparam int unsigned DEPTH_MAX = 32;

   // Bits needed to count 0..depth occupied stages.
   function automatic int unsigned fill_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: W data bits plus a valid bit, with hold on !en and a valid-only clear.
module dff_stage #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] data_i,
   input  logic         valid_i,
   output logic [W-1:0] data_o,
   output logic         valid_o
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;

   // Clear drops only the valid bit; the data word is left in place.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clr_i) begin
         valid_d = 1'b0;
      end else if (en_i) begin
         data_d  = data_i;
         valid_d = valid_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/dff_delay_line.sv
// Enabled, flushable DEPTH-stage delay line with valid tracking and occupancy count.
// Optional per-stage even parity is built when DFF_DELAY_LINE_PARITY_EN is defined.
module dff_delay_line
   import dff_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              d,
   input  logic                          d_valid,
`ifdef DFF_DELAY_LINE_PARITY_EN
   input  logic                          perr_inject,
   output logic                          q_perr,
`endif
   output logic [WIDTH-1:0]              q,
   output logic                          q_valid,
   output logic [fill_width(DEPTH)-1:0]  fill_count
);

   localparam int unsigned CW = fill_width(DEPTH);
`ifdef DFF_DELAY_LINE_PARITY_EN
   localparam int unsigned SW = WIDTH + 1;
`else
   localparam int unsigned SW = WIDTH;
`endif

   if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
      $fatal(1, "dff_delay_line: WIDTH out of range 1..64");
   end
   if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $fatal(1, "dff_delay_line: DEPTH out of range 1..32");
   end

   // Index k is the input of stage k; index DEPTH is the output of the last stage.
   logic [DEPTH:0][SW-1:0] stage_data;
   logic [DEPTH:0]         stage_valid;

`ifdef DFF_DELAY_LINE_PARITY_EN
   assign stage_data[0] = {(^d) ^ perr_inject, d};
`else
   assign stage_data[0] = d;
`endif
   assign stage_valid[0] = d_valid;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      dff_stage #(
         .W (SW)
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .en_i    (en),
         .clr_i   (flush),
         .data_i  (stage_data[k]),
         .valid_i (stage_valid[k]),
         .data_o  (stage_data[k+1]),
         .valid_o (stage_valid[k+1])
      );
   end

   logic [CW-1:0] fill_q, fill_d;

   // Occupancy moves in lockstep with the valid bits: +1 entering, -1 leaving.
   always_comb begin
      fill_d = fill_q;
      if (flush) begin
         fill_d = '0;
      end else if (en) begin
         fill_d = fill_q + CW'(d_valid) - CW'(stage_valid[DEPTH]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q <= '0;
      end else begin
         fill_q <= fill_d;
      end
   end

   assign q          = stage_data[DEPTH][WIDTH-1:0];
   assign q_valid    = stage_valid[DEPTH];
   assign fill_count = fill_q;

`ifdef DFF_DELAY_LINE_PARITY_EN
   assign q_perr = q_valid & ((^q) ^ stage_data[DEPTH][WIDTH]);
`endif

endmodule

// File: tb/tb_dff_delay_line.sv
// Bench for dff_delay_line: DEPTH=4 and DEPTH=1 instances share stimulus, checked against queues.
module tb_dff_delay_line;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] d = '0;
   logic       d_valid = 1'b0;
   logic       perr = 1'b0;

   logic [7:0] q4, q1;
   logic       qv4, qv1;
   logic [2:0] fc4;
   logic [0:0] fc1;
   logic       qp4, qp1;

   int checks = 0;
   int errors = 0;

   // Model entries: [9] parity-corrupted, [8] valid, [7:0] data; index 0 is stage 0.
   logic [9:0] m4[$];
   logic [9:0] m1[$];

   always #5 clk = ~clk;

   dff_delay_line #(
      .WIDTH (8),
      .DEPTH (4)
   ) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .flush      (flush),
      .d          (d),
      .d_valid    (d_valid),
`ifdef DFF_DELAY_LINE_PARITY_EN
      .perr_inject(perr),
      .q_perr     (qp4),
`endif
      .q          (q4),
      .q_valid    (qv4),
      .fill_count (fc4)
   );

   dff_delay_line #(
      .WIDTH (8),
      .DEPTH (1)
   ) u_dut1 (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .flush      (flush),
      .d          (d),
      .d_valid    (d_valid),
`ifdef DFF_DELAY_LINE_PARITY_EN
      .perr_inject(perr),
      .q_perr     (qp1),
`endif
      .q          (q1),
      .q_valid    (qv1),
      .fill_count (fc1)
   );

`ifndef DFF_DELAY_LINE_PARITY_EN
   assign qp4 = 1'b0;
   assign qp1 = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m4 = {10'h0, 10'h0, 10'h0, 10'h0};
      m1 = {10'h0};
   endtask

   function automatic int unsigned pop_valid(input logic [9:0] m[$]);
      int unsigned n = 0;
      foreach (m[i]) n += m[i][8];
      return n;
   endfunction

   task automatic model_check();
      logic [9:0] e4, e1;
      e4 = m4[3];
      e1 = m1[0];
      chk("d4_q", q4, e4[7:0]);
      chk("d4_q_valid", qv4, e4[8]);
      chk("d4_fill", fc4, pop_valid(m4));
      chk("d1_q", q1, e1[7:0]);
      chk("d1_q_valid", qv1, e1[8]);
      chk("d1_fill", fc1, pop_valid(m1));
`ifdef DFF_DELAY_LINE_PARITY_EN
      chk("d4_q_perr", qp4, e4[9] & e4[8]);
      chk("d1_q_perr", qp1, e1[9] & e1[8]);
`endif
   endtask

   task automatic step(input logic e, input logic f, input logic v, input logic [7:0] dd,
                       input logic pe = 1'b0);
      en = e;
      flush = f;
      d_valid = v;
      d = dd;
      perr = pe;
      @(posedge clk);
      if (f) begin
         foreach (m4[i]) m4[i][8] = 1'b0;
         foreach (m1[i]) m1[i][8] = 1'b0;
      end else if (e) begin
         m4.push_front({pe, v, dd});
         m4.delete(4);
         m1.push_front({pe, v, dd});
         m1.delete(1);
      end
      #1;
      model_check();
   endtask

   initial begin
      model_reset();
      #1;
      chk("reset_q", q4, 8'h00);
      chk("reset_q_valid", qv4, 1'b0);
      chk("reset_fill", fc4, 3'd0);
      #11 rst = 1'b0;

      // Single word latency: visible on the 4th enabled edge, for one cycle.
      step(1'b1, 1'b0, 1'b1, 8'hA5);
      chk("d1_latency_q", q1, 8'hA5);
      step(1'b1, 1'b0, 1'b0, 8'h3C);
      chk("d1_drop_valid", qv1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("latency_q", q4, 8'hA5);
      chk("latency_q_valid", qv4, 1'b1);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("latency_one_cycle", qv4, 1'b0);

      // Stall on edges 2 and 3: word emerges on edge 6.
      step(1'b1, 1'b0, 1'b1, 8'hA5);
      step(1'b0, 1'b0, 1'b1, 8'hFF);
      chk("stall_fill", fc4, 3'd1);
      step(1'b0, 1'b0, 1'b0, 8'hEE);
      chk("stall_fill2", fc4, 3'd1);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("stall_not_yet", qv4, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("stall_q", q4, 8'hA5);
      chk("stall_q_valid", qv4, 1'b1);

      // Fill then flush: data holds, valids clear.
      step(1'b1, 1'b1, 1'b0, 8'h00);
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, 8'(i));
      chk("fill_full", fc4, 3'd4);
      step(1'b1, 1'b1, 1'b1, 8'h77);
      chk("flush_fill", fc4, 3'd0);
      chk("flush_q_valid", qv4, 1'b0);
      chk("flush_q_hold", q4, 8'h01);

      // Async reset between edges with three words in flight.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h70 + i));
      chk("pre_reset_fill", fc4, 3'd3);
      rst = 1'b1;
      #2;
      chk("async_q", q4, 8'h00);
      chk("async_q_valid", qv4, 1'b0);
      chk("async_fill", fc4, 3'd0);
      chk("async_d1_q", q1, 8'h00);
      rst = 1'b0;
      model_reset();
      step(1'b1, 1'b0, 1'b1, 8'h5A);
      chk("post_reset_capture", q1, 8'h5A);

      // Parity injection visible 4 edges later; clean words never flag.
      step(1'b1, 1'b0, 1'b1, 8'h01, 1'b1);
      step(1'b1, 1'b0, 1'b1, 8'h01, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef DFF_DELAY_LINE_PARITY_EN
      chk("perr_flag", qp4, 1'b1);
`endif
      step(1'b1, 1'b0, 1'b0, 8'h00);
`ifdef DFF_DELAY_LINE_PARITY_EN
      chk("perr_clean", qp4, 1'b0);
`endif

      for (int i = 0; i < 300; i++) begin
         step($urandom_range(3) != 0, $urandom_range(9) == 0, 1'($urandom),
              8'($urandom), $urandom_range(7) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
